ram_port_arbiter: RTL

//  Shares one 64-bit single-port SRAM between g_nports bus-to-RAM bridge instances.

---
 rtl/ram_port_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one 64-bit single-port SRAM between g_nports bridge ports.
// Arbitration is round-robin. The current owner may keep the grant for up to
// g_max_burst consecutive cycles while another port is requesting. With no
// competing request it keeps the grant indefinitely.
// The granted port's access is muxed onto the SRAM combinationally. A read
// issued in cycle n is flagged back to its port in cycle n+1.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   req                per-port request
//   gnt                one-hot grant (combinational, zero while rst)
//   port_cs/asel       per-port chip select / held-access select
//   port_a0/a1         per-port word addresses, port i at [i*(AW-3) +: AW-3]
//   port_we0/we1       per-port byte enables, port i at [i*8 +: 8]
//   port_rdata         SRAM read word, broadcast to all ports
//   port_rvalid        one-hot read-return strobe
//   sram_cs/a/we       SRAM access, driven by the granted port
//   sram_rdata         SRAM read data, valid the cycle after a read
module ram_port_arbiter #(
  parameter int g_addr_width = 15,
  parameter int g_nports     = 2,
  parameter int g_max_burst  = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [g_nports-1:0]                 req,
  output logic [g_nports-1:0]                 gnt,
  input  logic [g_nports-1:0]                 port_cs,
  input  logic [g_nports-1:0]                 port_asel,
  input  logic [g_nports*(g_addr_width-3)-1:0] port_a0,
  input  logic [g_nports*(g_addr_width-3)-1:0] port_a1,
  input  logic [g_nports*8-1:0]               port_we0,
  input  logic [g_nports*8-1:0]               port_we1,
  output logic [63:0]                         port_rdata,
  output logic [g_nports-1:0]                 port_rvalid,
  output logic                                sram_cs,
  output logic [g_addr_width-4:0]             sram_a,
  output logic [7:0]                          sram_we,
  input  logic [63:0]                         sram_rdata
);

  localparam int WA = g_addr_width - 3;
  localparam int IW = (g_nports > 2) ? 2 : 1;
  localparam logic [3:0] MAXB = 4'(g_max_burst);

  logic [g_nports-1:0] ptr;
  logic [IW-1:0]       owner;
  logic                owner_vld;
  logic [3:0]          bcnt;
  logic [g_nports-1:0] rd_sel;

  logic [IW-1:0]       pidx;
  logic [IW-1:0]       scan_idx;
  logic                scan_found;
  logic [g_nports-1:0] others;
  logic                hold;
  logic [IW-1:0]       gidx;
  logic                gany;
  logic [g_nports-1:0] gnt_oh;

  // Binary index of the one-hot priority pointer.
  always_comb begin
    pidx = '0;
    for (int i = 0; i < g_nports; i++) begin
      pidx = ptr[i] ? IW'(i) : pidx;
    end
  end

  // First requester at or after ptr, wrapping around.
  always_comb begin
    logic [IW:0] jw;
    scan_found = 1'b0;
    scan_idx   = '0;
    jw         = '0;
    for (int i = 0; i < g_nports; i++) begin
      jw = {1'b0, pidx} + (IW+1)'(i);
      if (jw >= (IW+1)'(g_nports)) begin
        jw = jw - (IW+1)'(g_nports);
      end else begin
        jw = jw;
      end
      if (!scan_found && req[jw[IW-1:0]]) begin
        scan_found = 1'b1;
        scan_idx   = jw[IW-1:0];
      end else begin
        scan_found = scan_found;
      end
    end
  end

  // Grant selection: the owner holds unless its burst is used up and someone else waits.
  always_comb begin
    others = req & ~(g_nports'(1) << owner);
    hold   = owner_vld && req[owner] && ((bcnt < MAXB) || (others == '0));
    gidx   = hold ? owner : scan_idx;
    gany   = !rst && (hold || scan_found);
    gnt_oh = g_nports'(1) << gidx;
    gnt    = gany ? gnt_oh : '0;
  end

  // SRAM access mux from the granted port.
  always_comb begin
    sram_cs = 1'b0;
    sram_a  = '0;
    sram_we = 8'h00;
    if (gany) begin
      sram_cs = port_cs[gidx];
      sram_a  = port_asel[gidx] ? port_a1[int'(gidx)*WA +: WA]
                                : port_a0[int'(gidx)*WA +: WA];
      if (port_cs[gidx]) begin
        sram_we = port_asel[gidx] ? port_we1[int'(gidx)*8 +: 8]
                                  : port_we0[int'(gidx)*8 +: 8];
      end else begin
        sram_we = 8'h00;
      end
    end else begin
      sram_cs = 1'b0;
    end
  end

  // Read return is gated during reset so a pending return never escapes.
  always_comb begin
    port_rvalid = rst ? '0 : rd_sel;
    port_rdata  = sram_rdata;
  end

  // Ownership, burst count, priority pointer and read-return select.
  // A grant to a port that is not the valid owner (including re-grant after an
  // idle cycle) starts a new burst and moves the pointer past that port.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= g_nports'(1);
      owner     <= '0;
      owner_vld <= 1'b0;
      bcnt      <= 4'd0;
      rd_sel    <= '0;
    end else begin
      if (gany) begin
        if (owner_vld && (gidx == owner)) begin
          bcnt <= (bcnt == 4'd15) ? 4'd15 : bcnt + 4'd1;
        end else begin
          owner     <= gidx;
          owner_vld <= 1'b1;
          bcnt      <= 4'd1;
          ptr       <= {gnt_oh[g_nports-2:0], gnt_oh[g_nports-1]};
        end
      end else begin
        owner_vld <= 1'b0;
        bcnt      <= 4'd0;
      end
      rd_sel <= (gany && sram_cs && (sram_we == 8'h00)) ? gnt : '0;
    end
  end

endmodule
